// File: rtl/coeff_fetch_if.sv
// coeff_fetch_if: ROM read port, coefficient stream and control handshake of the coefficient fetch sequencer.
interface coeff_fetch_if #(
   parameter int COEFF_WIDTH = 16,
   parameter int DEPTH       = 6
);
   localparam int ADDR_W = $clog2(DEPTH);
   logic                          start;
   logic                          abort;
   logic                          rom_en;
   logic        [ADDR_W-1:0]      rom_addr_re;
   logic        [ADDR_W-1:0]      rom_addr_im;
   logic signed [COEFF_WIDTH-1:0] rom_data_re;
   logic signed [COEFF_WIDTH-1:0] rom_data_im;
   logic                          coef_valid;
   logic                          coef_ready;
   logic        [ADDR_W-1:0]      coef_idx;
   logic signed [COEFF_WIDTH-1:0] coef_re;
   logic signed [COEFF_WIDTH-1:0] coef_im;
   logic                          busy;
   logic                          done;
   modport master (
      input  start, abort, rom_data_re, rom_data_im, coef_ready,
      output rom_en, rom_addr_re, rom_addr_im, coef_valid, coef_idx, coef_re, coef_im, busy, done
   );
   modport slave (
      output start, abort, rom_data_re, rom_data_im, coef_ready,
      input  rom_en, rom_addr_re, rom_addr_im, coef_valid, coef_idx, coef_re, coef_im, busy, done
   );
endinterface

// File: rtl/coeff_fetch_ctrl.sv
// coeff_fetch_ctrl: streams coefficients 0..DEPTH-1 from the registered ROM to the DPD loader,
// stalling the ROM enable under backpressure so the ROM output register is the only buffer.
module coeff_fetch_ctrl #(
   parameter int COEFF_WIDTH = 16,
   parameter int DEPTH       = 6
) (
   input logic          clk,
   input logic          rst,
   coeff_fetch_if.master bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH-1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            state, state_n;
   logic [ADDR_W:0]   cnt, cnt_n;
   logic              valid_n;
   logic [ADDR_W-1:0] idx_n;
   logic              fire, accept;
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      valid_n = bus.coef_valid;
      idx_n   = bus.coef_idx;
      fire    = state == RUN && cnt < CNT_MAX && (!bus.coef_valid || bus.coef_ready) && !bus.abort;
      accept  = bus.coef_valid && bus.coef_ready && !bus.abort;
      if (state == IDLE) begin
         if (bus.start && !bus.abort) begin
            state_n = RUN;
            cnt_n   = '0;
         end
      end else if (state == RUN) begin
         if (bus.abort) begin
            state_n = IDLE;
            valid_n = 1'b0;
            cnt_n   = '0;
         end else if (accept && bus.coef_idx == IDX_LAST) begin
            state_n = DONE;
            valid_n = 1'b0;
         end else if (fire) begin
            cnt_n   = cnt + 1'b1;
            valid_n = 1'b1;
            idx_n   = cnt[ADDR_W-1:0];
         end else if (accept) begin
            valid_n = 1'b0;
         end
      end else begin
         state_n = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.coef_valid <= 1'b0;
         bus.coef_idx   <= '0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         bus.coef_valid <= valid_n;
         bus.coef_idx   <= idx_n;
      end
   end
   // Past the last issue the count sits at DEPTH, which is not a legal address.
   assign bus.rom_addr_re = cnt < CNT_MAX ? cnt[ADDR_W-1:0] : '0;
   assign bus.rom_addr_im = bus.rom_addr_re;
   assign bus.rom_en      = fire;
   assign bus.busy        = state == RUN;
   assign bus.done        = state == DONE;
   assign bus.coef_re     = bus.rom_data_re;
   assign bus.coef_im     = bus.rom_data_im;
endmodule

// File: tb/tb_coeff_fetch_ctrl.sv
// tb_coeff_fetch_ctrl: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_coeff_fetch_ctrl;
   localparam int CW = 16;
   localparam int DEPTH = 6;
   typedef struct {int idx; int re; int im;} beat_t;
   logic clk = 0;
   logic rst;
   int checks = 0;
   int passed = 0;
   int done_cnt = 0;
   beat_t q[$];
   beat_t e;
   coeff_fetch_if #(.COEFF_WIDTH(CW), .DEPTH(DEPTH)) bus ();
   coeff_fetch_ctrl #(.COEFF_WIDTH(CW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // ROM model: re = 0x0100+addr, im = 0x0F00+addr, one-cycle registered read
   always @(posedge clk) begin
      if (bus.rom_en) begin
         bus.rom_data_re <= 16'h0100 + 16'(bus.rom_addr_re);
         bus.rom_data_im <= 16'h0F00 + 16'(bus.rom_addr_im);
      end
   end
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.done) done_cnt++;
         if (bus.coef_valid && bus.coef_ready && !bus.abort) begin
            if (q.size() == 0) chk("unexpected_beat", bus.coef_idx, -1);
            else begin
               e = q.pop_front();
               chk("beat_idx", bus.coef_idx, e.idx);
               chk("beat_re", bus.coef_re, e.re);
               chk("beat_im", bus.coef_im, e.im);
            end
         end
         if (bus.coef_valid && !bus.coef_ready) chk("stall_rom_en", bus.rom_en, 0);
      end
   end
   task automatic start_seq();
      for (int i = 0; i < DEPTH; i++) q.push_back('{i, 32'h0100 + i, 32'h0F00 + i});
      bus.start = 1;
      @(posedge clk); #1;
      bus.start = 0;
   endtask
   task automatic wait_idx(input int n, input string name);
      int k = 0;
      while (!(bus.coef_valid && bus.coef_idx == n) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk(name, bus.coef_valid && bus.coef_idx == n, 1);
   endtask
   task automatic wait_done(input string name, input bit rnd);
      int k = 0;
      while (!bus.done && k < 300) begin
         if (rnd) bus.coef_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         k++;
      end
      bus.coef_ready = 1;
      chk(name, bus.done, 1);
   endtask
   task automatic finish_seq(input string name, input int d0);
      @(posedge clk); #1;
      chk({name, "_done_count"}, done_cnt, d0 + 1);
      chk({name, "_sb_empty"}, q.size(), 0);
      chk({name, "_idle"}, bus.busy, 0);
   endtask
   task automatic check_reset_outputs(input string name);
      chk({name, "_valid"}, bus.coef_valid, 0);
      chk({name, "_busy"}, bus.busy, 0);
      chk({name, "_done"}, bus.done, 0);
      chk({name, "_rom_en"}, bus.rom_en, 0);
      chk({name, "_addr"}, bus.rom_addr_re, 0);
      chk({name, "_idx"}, bus.coef_idx, 0);
   endtask
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int d0;
      rst = 1;
      bus.start = 0;
      bus.abort = 0;
      bus.coef_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 0;
      @(posedge clk); #1;
      // nominal timing, cycle k counted from the edge that samples start
      d0 = done_cnt;
      start_seq();
      for (int k = 1; k <= 9; k++) begin
         chk($sformatf("nom_busy_c%0d", k), bus.busy, (k <= 7) ? 1 : 0);
         chk($sformatf("nom_rom_en_c%0d", k), bus.rom_en, (k <= 6) ? 1 : 0);
         chk($sformatf("nom_valid_c%0d", k), bus.coef_valid, (k >= 2 && k <= 7) ? 1 : 0);
         chk($sformatf("nom_done_c%0d", k), bus.done, (k == 8) ? 1 : 0);
         if (k <= 6) chk($sformatf("nom_addr_c%0d", k), bus.rom_addr_im, k - 1);
         if (k >= 2 && k <= 7) chk($sformatf("nom_idx_c%0d", k), bus.coef_idx, k - 2);
         @(posedge clk); #1;
      end
      chk("nom_done_count", done_cnt, d0 + 1);
      chk("nom_sb_empty", q.size(), 0);
      // backpressure on idx2
      d0 = done_cnt;
      start_seq();
      wait_idx(2, "bp_reach_idx2");
      bus.coef_ready = 0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_idx", bus.coef_idx, 2);
         chk("bp_hold_re", bus.coef_re, 32'h0102);
         chk("bp_hold_im", bus.coef_im, 32'h0F02);
         chk("bp_hold_valid", bus.coef_valid, 1);
         @(posedge clk); #1;
      end
      bus.coef_ready = 1;
      @(posedge clk); #1;
      chk("bp_next_idx", bus.coef_idx, 3);
      chk("bp_next_valid", bus.coef_valid, 1);
      wait_done("bp_done", 0);
      finish_seq("bp", d0);
      // random backpressure
      for (int s = 0; s < 20; s++) begin
         d0 = done_cnt;
         start_seq();
         wait_done($sformatf("rnd%0d_done", s), 1);
         finish_seq($sformatf("rnd%0d", s), d0);
      end
      // abort after idx3 handshake
      d0 = done_cnt;
      start_seq();
      wait_idx(3, "ab_reach_idx3");
      @(posedge clk); #1;
      bus.abort = 1;
      @(posedge clk); #1;
      bus.abort = 0;
      chk("ab_valid", bus.coef_valid, 0);
      chk("ab_busy", bus.busy, 0);
      chk("ab_remaining", q.size(), 2);
      q.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("ab_no_done", done_cnt, d0);
      chk("ab_still_idle", bus.busy, 0);
      d0 = done_cnt;
      start_seq();
      wait_done("ab_restart_done", 0);
      finish_seq("ab_restart", d0);
      // start while busy is ignored
      d0 = done_cnt;
      start_seq();
      wait_idx(1, "sb_reach_idx1");
      bus.start = 1;
      @(posedge clk); #1;
      bus.start = 0;
      wait_done("sb_done", 0);
      finish_seq("sb", d0);
      repeat (2) @(posedge clk);
      #1;
      chk("sb_no_restart", bus.busy, 0);
      // start with abort in IDLE is ignored
      bus.start = 1;
      bus.abort = 1;
      @(posedge clk); #1;
      bus.start = 0;
      bus.abort = 0;
      chk("sa_busy", bus.busy, 0);
      chk("sa_rom_en", bus.rom_en, 0);
      @(posedge clk); #1;
      chk("sa_valid", bus.coef_valid, 0);
      // start in DONE cycle is ignored
      d0 = done_cnt;
      start_seq();
      wait_done("sd_done", 0);
      bus.start = 1;
      @(posedge clk); #1;
      bus.start = 0;
      chk("sd_busy", bus.busy, 0);
      chk("sd_rom_en", bus.rom_en, 0);
      @(posedge clk); #1;
      chk("sd_busy2", bus.busy, 0);
      chk("sd_valid", bus.coef_valid, 0);
      chk("sd_done_count", done_cnt, d0 + 1);
      // asynchronous reset mid-sequence
      start_seq();
      wait_idx(2, "rs_reach_idx2");
      #2 rst = 1;
      #1;
      check_reset_outputs("rs_async");
      q.delete();
      @(posedge clk); #1;
      rst = 0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("rs_quiet_busy", bus.busy, 0);
         chk("rs_quiet_rom_en", bus.rom_en, 0);
      end
      d0 = done_cnt;
      start_seq();
      wait_done("rs_restart_done", 0);
      finish_seq("rs_restart", d0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
